// File: rtl/alu_instr_sequencer.sv
// Control-step sequencer for fetch plus register-register ALU instructions.
// Outputs are a Moore decode of the step state and the IR fields held by the datapath.
//
// state  | meaning
// S_IDLE | waiting for start
// S_T0   | PC -> MAR, increment PC into Z
// S_T1   | Z -> PC, memory read into MDR
// S_T2   | MDR -> IR
// S_T3   | first operand step (or no-op for illegal opcodes)
// S_T4   | second operand / unary result step
// S_T5   | low result write-back
// S_T6   | high result write-back (mul/div only)
// S_DONE | one-cycle completion pulse
module alu_instr_sequencer #(
    parameter int NREGS = 16,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stall,
    input  logic [31:0]      ir,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             Zin,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             ZLOout,
    output logic             ZHIout,
    output logic             Loin,
    output logic             HIin,
    output logic [NREGS-1:0] rin,
    output logic [NREGS-1:0] rout,
    output logic [OPW-1:0]   alu_opcode
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [OPW-1:0]   opcode;
    logic [3:0]       ra, rb, rc;
    logic [NREGS-1:0] ra_hot, rb_hot, rc_hot;
    logic             is_bin, is_muldiv, is_unary, is_legal;
    logic             unused_ir_bits;

    assign opcode         = ir[31 -: OPW];
    assign ra             = ir[26:23];
    assign rb             = ir[22:19];
    assign rc             = ir[18:15];
    assign unused_ir_bits = ^ir[14:0];

    assign is_bin    = (opcode >= OPW'(3)) && (opcode <= OPW'(11));
    assign is_muldiv = (opcode == OPW'(15)) || (opcode == OPW'(16));
    assign is_unary  = (opcode == OPW'(17)) || (opcode == OPW'(18));
    assign is_legal  = is_bin || is_muldiv || is_unary;

    always_comb begin
        ra_hot     = '0;
        rb_hot     = '0;
        rc_hot     = '0;
        ra_hot[ra] = 1'b1;
        rb_hot[rb] = 1'b1;
        rc_hot[rc] = 1'b1;
    end

    // stall freezes the step; since outputs decode state and ir, they freeze too
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state <= S_IDLE;
        else if (!stall)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        illegal    = 1'b0;
        {PCout, MARin, IncPC, Zin, PCin, Read, MDRin} = '0;
        {MDRout, IRin, Yin, ZLOout, ZHIout, Loin, HIin} = '0;
        rin        = '0;
        rout       = '0;
        alu_opcode = '0;
        case (state)
            S_IDLE: if (start) state_nxt = S_T0;
            S_T0: begin
                {PCout, MARin, IncPC, Zin} = 4'b1111;
                state_nxt = S_T1;
            end
            S_T1: begin
                {ZLOout, PCin, Read, MDRin} = 4'b1111;
                state_nxt = S_T2;
            end
            S_T2: begin
                {MDRout, IRin} = 2'b11;
                state_nxt = S_T3;
            end
            S_T3: begin
                if (is_bin) begin
                    rout = rb_hot;
                    Yin  = 1'b1;
                end else if (is_muldiv) begin
                    rout = ra_hot;
                    Yin  = 1'b1;
                end else if (is_unary) begin
                    rout       = rb_hot;
                    alu_opcode = opcode;
                    Zin        = 1'b1;
                end
                state_nxt = is_legal ? S_T4 : S_DONE;
            end
            S_T4: begin
                state_nxt = S_DONE;
                if (is_bin || is_muldiv) begin
                    rout       = is_bin ? rc_hot : rb_hot;
                    alu_opcode = opcode;
                    Zin        = 1'b1;
                    state_nxt  = S_T5;
                end else if (is_unary) begin
                    ZLOout = 1'b1;
                    rin    = ra_hot;
                end
            end
            S_T5: begin
                state_nxt = S_DONE;
                if (is_bin) begin
                    ZLOout = 1'b1;
                    rin    = ra_hot;
                end else if (is_muldiv) begin
                    ZLOout    = 1'b1;
                    Loin      = 1'b1;
                    state_nxt = S_T6;
                end
            end
            S_T6: begin
                ZHIout    = is_muldiv;
                HIin      = is_muldiv;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                illegal   = !is_legal;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
